// File: rtl/gate_checker_if.sv
// Handshake bundle between a gate-unit stimulus source and the gate_checker.
// The master drives the vector and start; the slave reports run status and results.
interface gate_checker_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             vld;
    logic             a;
    logic             b;
    logic             c;
    logic             d;
    logic             e;
    logic             x;
    logic             y;
    logic             z;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] vec_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] ff_idx;
    logic [5:0]       ff_mask;
    logic             ff_vld;

    modport master (
        output start, vld, a, b, c, d, e, x, y, z,
        input  busy, done, pass, vec_cnt, err_cnt, ff_idx, ff_mask, ff_vld
    );

    modport slave (
        input  start, vld, a, b, c, d, e, x, y, z,
        output busy, done, pass, vec_cnt, err_cnt, ff_idx, ff_mask, ff_vld
    );
endinterface

// File: rtl/gate_checker.sv
// Checks NUM_VEC responses of a two-input gate unit against and/or/xor/nand/nor/xnor,
// counting failing vectors and capturing the first failure.
module gate_checker #(
    parameter int NUM_VEC = 10,
    parameter int CNT_W   = 8
) (
    input logic           clk,
    input logic           rst,
    gate_checker_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Case inequality flags X/Z responses in simulation; synthesis sees plain inequality.
    function automatic logic [5:0] calc_mask(input logic a, input logic b,
                                             input logic [5:0] resp);
        logic [5:0] gold;
        logic [5:0] m;
        gold = {~(a ^ b), ~(a | b), ~(a & b), a ^ b, a | b, a & b};
        for (int i = 0; i < 6; i++) begin
            m[i] = (resp[i] !== gold[i]);
        end
        return m;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_t           state;
    logic             armed;
    logic             busy_r;
    logic             done_r;
    logic             pass_r;
    logic [CNT_W-1:0] vec_cnt_r;
    logic [CNT_W-1:0] err_cnt_r;
    logic [CNT_W-1:0] ff_idx_r;
    logic [5:0]       ff_mask_r;
    logic             ff_vld_r;

    logic [5:0]       mask;
    logic [CNT_W-1:0] vec_nxt;
    logic             last_vec;

    always_comb begin
        mask     = calc_mask(bus.a, bus.b, {bus.z, bus.y, bus.x, bus.e, bus.d, bus.c});
        vec_nxt  = vec_cnt_r + CNT_W'(1);
        last_vec = (vec_nxt == CNT_W'(NUM_VEC));
    end

    // armed masks start/vld on the first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            armed     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            pass_r    <= 1'b0;
            vec_cnt_r <= '0;
            err_cnt_r <= '0;
            ff_idx_r  <= '0;
            ff_mask_r <= '0;
            ff_vld_r  <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (armed) begin
                case (state)
                    IDLE, DONE: begin
                        if (bus.start) begin
                            state     <= RUN;
                            busy_r    <= 1'b1;
                            done_r    <= 1'b0;
                            pass_r    <= 1'b0;
                            vec_cnt_r <= '0;
                            err_cnt_r <= '0;
                            ff_idx_r  <= '0;
                            ff_mask_r <= '0;
                            ff_vld_r  <= 1'b0;
                        end
                    end
                    RUN: begin
                        if (bus.vld) begin
                            vec_cnt_r <= vec_nxt;
                            if (|mask) begin
                                err_cnt_r <= sat_inc(err_cnt_r);
                                if (!ff_vld_r) begin
                                    ff_idx_r  <= vec_cnt_r;
                                    ff_mask_r <= mask;
                                    ff_vld_r  <= 1'b1;
                                end
                            end
                            // The closing vector is counted and judged on the same edge.
                            if (last_vec) begin
                                state  <= DONE;
                                busy_r <= 1'b0;
                                done_r <= 1'b1;
                                pass_r <= (err_cnt_r == '0) && (mask == 6'd0);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.pass    = pass_r;
    assign bus.vec_cnt = vec_cnt_r;
    assign bus.err_cnt = err_cnt_r;
    assign bus.ff_idx  = ff_idx_r;
    assign bus.ff_mask = ff_mask_r;
    assign bus.ff_vld  = ff_vld_r;
endmodule

// File: tb/tb_gate_checker.sv
// Self-checking bench for gate_checker: table-driven run, hand-written corner sequences,
// and randomized runs against a queue-based reference model.
module tb_gate_checker;
    localparam int NV = 10;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gate_checker_if #(.CNT_W(CW)) bus ();
    gate_checker #(.NUM_VEC(NV), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: run flags plus the list of masks accepted in the current run.
    bit         m_armed;
    bit         m_run;
    bit         m_done;
    logic [5:0] m_masks[$];

    typedef struct {
        bit       a;
        bit       b;
        bit [5:0] flip;
        int       exp_vec;
        int       exp_err;
    } vec_rec_t;

    vec_rec_t tbl[10];

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Responses of a correct gate unit, written as arithmetic on 0/1 operands: {z,y,x,e,d,c}.
    function automatic logic [5:0] gold(input bit a, input bit b);
        int s, p;
        bit g_and, g_or, g_xor;
        s = int'(a) + int'(b);
        p = int'(a) * int'(b);
        g_and = (p == 1);
        g_or  = (s >= 1);
        g_xor = (s == 1);
        return {!g_xor, !g_or, !g_and, g_xor, g_or, g_and};
    endfunction

    task automatic check_all(input string tag);
        int err, ffi;
        bit ffv;
        logic [5:0] ffm;
        err = 0; ffi = 0; ffv = 0; ffm = '0;
        foreach (m_masks[i]) begin
            if (m_masks[i] != 6'd0) begin
                if (!ffv) begin
                    ffv = 1; ffi = i; ffm = m_masks[i];
                end
                if (err < (1 << CW) - 1) err++;
            end
        end
        chk({tag, ".busy"}, int'(bus.busy), int'(m_run));
        chk({tag, ".done"}, int'(bus.done), int'(m_done));
        chk({tag, ".pass"}, int'(bus.pass), int'(m_done && err == 0));
        chk({tag, ".vec_cnt"}, int'(bus.vec_cnt), m_masks.size());
        chk({tag, ".err_cnt"}, int'(bus.err_cnt), err);
        chk({tag, ".ff_vld"}, int'(bus.ff_vld), int'(ffv));
        chk({tag, ".ff_idx"}, int'(bus.ff_idx), ffi);
        chk({tag, ".ff_mask"}, int'(bus.ff_mask), int'(ffm));
    endtask

    // One clock: drive inputs, take the edge, advance the model, sample 1 time unit later.
    task automatic step(input bit st, input bit v, input bit a, input bit b,
                        input logic [5:0] resp, input string tag);
        logic [5:0] g, m;
        bus.start = st; bus.vld = v; bus.a = a; bus.b = b;
        {bus.z, bus.y, bus.x, bus.e, bus.d, bus.c} = resp;
        @(posedge clk);
        g = gold(a, b);
        for (int i = 0; i < 6; i++) m[i] = (resp[i] !== g[i]);
        if (!m_armed) begin
            m_armed = 1;
        end else if (!m_run && st) begin
            m_run = 1; m_done = 0; m_masks.delete();
        end else if (m_run && v) begin
            m_masks.push_back(m);
            if (m_masks.size() == NV) begin
                m_run = 0; m_done = 1;
            end
        end
        #1;
        check_all(tag);
        bus.start = 1'b0; bus.vld = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        #2 rst = 1'b1;
        m_armed = 0; m_run = 0; m_done = 0; m_masks.delete();
        #1 check_all(tag);
        @(posedge clk); #2;
        check_all(tag);
        rst = 1'b0;
    endtask

    task automatic vec_step(input bit a, input bit b, input bit [5:0] flip, input string tag);
        step(1'b0, 1'b1, a, b, gold(a, b) ^ flip, tag);
    endtask

    initial begin
        int cyc;
        bit ra, rb;
        bus.start = 0; bus.vld = 0; bus.a = 0; bus.b = 0;
        {bus.z, bus.y, bus.x, bus.e, bus.d, bus.c} = '0;
        rst = 1'b1;
        m_armed = 0; m_run = 0; m_done = 0;

        // Injected fault: c stuck at 0 when a=b=1.
        tbl[0] = '{0, 1, 6'd0, 1, 0};
        tbl[1] = '{1, 0, 6'd0, 2, 0};
        tbl[2] = '{1, 1, 6'd1, 3, 1};
        tbl[3] = '{0, 0, 6'd0, 4, 1};
        tbl[4] = '{1, 1, 6'd1, 5, 2};
        tbl[5] = '{0, 1, 6'd0, 6, 2};
        tbl[6] = '{1, 1, 6'd1, 7, 3};
        tbl[7] = '{1, 0, 6'd0, 8, 3};
        tbl[8] = '{0, 0, 6'd0, 9, 3};
        tbl[9] = '{1, 1, 6'd1, 10, 4};

        do_reset("reset");
        step(1'b1, 1'b1, 1'b0, 1'b0, gold(0, 0), "rel_edge");
        chk("rel_edge_ignored", int'(bus.busy), 0);

        step(1'b1, 1'b0, 1'b0, 1'b0, gold(0, 0), "start1");
        foreach (tbl[i]) begin
            vec_step(tbl[i].a, tbl[i].b, tbl[i].flip, "tbl");
            chk("tbl.vec", int'(bus.vec_cnt), tbl[i].exp_vec);
            chk("tbl.err", int'(bus.err_cnt), tbl[i].exp_err);
        end
        chk("fault.ff_idx", int'(bus.ff_idx), 2);
        chk("fault.ff_mask", int'(bus.ff_mask), 1);
        chk("fault.pass", int'(bus.pass), 0);
        chk("fault.done", int'(bus.done), 1);

        // Restart from DONE, then a gapped run with start held high (ignored in RUN).
        step(1'b1, 1'b0, 1'b0, 1'b0, gold(0, 0), "restart");
        chk("restart.busy", int'(bus.busy), 1);
        chk("restart.err", int'(bus.err_cnt), 0);
        cyc = 0;
        while (!bus.done && cyc < 40) begin
            ra = 1'($urandom); rb = 1'($urandom);
            step(1'b1, (cyc % 2) == 0, ra, rb, gold(ra, rb), "gap");
            cyc++;
        end
        chk("gap.cycles", cyc, 19);
        for (int i = 0; i < 3; i++) vec_step(1'b1, 1'b0, 6'h3f, "done_vld");
        chk("done_vld.vec", int'(bus.vec_cnt), NV);

        // Reset mid-run, vld in IDLE, then a clean back-to-back run.
        step(1'b1, 1'b0, 1'b0, 1'b0, gold(0, 0), "start3");
        for (int i = 0; i < 5; i++) vec_step(1'(i), 1'(i >> 1), 6'd0, "partial");
        do_reset("midrst");
        step(1'b0, 1'b0, 1'b0, 1'b0, gold(0, 0), "idle");
        for (int i = 0; i < 3; i++) vec_step(1'b1, 1'b1, 6'h3f, "idle_vld");
        chk("idle_vld.vec", int'(bus.vec_cnt), 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, gold(0, 0), "start4");
        cyc = 0;
        while (!bus.done && cyc < 20) begin
            vec_step(1'($urandom), 1'($urandom), 6'd0, "clean");
            cyc++;
        end
        chk("clean.cycles", cyc, NV);
        chk("clean.pass", int'(bus.pass), 1);

        // Unknown response on z for a=b=1 (correct z is 1).
        step(1'b1, 1'b0, 1'b0, 1'b0, gold(0, 0), "start5");
        step(1'b0, 1'b1, 1'b1, 1'b1, {1'bx, gold(1, 1)[4:0]}, "xz");
        chk("xz.err", int'(bus.err_cnt), 1);
        chk("xz.mask5", int'(bus.ff_mask[5]), 1);
        for (int i = 0; i < NV - 1; i++) vec_step(1'b0, 1'b1, 6'd0, "xz_tail");

        // Randomized runs with gaps, sporadic faults and stray start pulses.
        for (int r = 0; r < 6; r++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, gold(0, 0), "rstart");
            cyc = 0;
            while (!bus.done && cyc < 60) begin
                ra = 1'($urandom); rb = 1'($urandom);
                step(($urandom % 5) == 0, ($urandom % 10) < 7, ra, rb,
                     gold(ra, rb) ^ (($urandom % 4 == 0) ? 6'($urandom) : 6'd0), "rand");
                cyc++;
            end
            chk("rand.done_in_budget", int'(bus.done), 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
